// File: rtl/mux_4x2_pkg.sv
// ---------------------------------------------------------------------------
// mux_4x2_pkg
// Shared definitions for the 4:1 multiplexer slice.
//   DEFAULT_WIDTH : default data width used by mux_4x2 and mux_4x2_core
//   sel_t         : 2-bit select encoding, S[1] is the MSB
//   SEL_A..SEL_D  : select codes that route A, B, C or D to the output
// ---------------------------------------------------------------------------
package mux_4x2_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage : mux_4x2_pkg

// File: rtl/mux_4x2_core.sv
// ---------------------------------------------------------------------------
// mux_4x2_core
// Purely combinational 4:1 word select.
// Ports:
//   A, B, C, D : WIDTH-bit data inputs
//   S          : 2-bit select (SEL_A..SEL_D)
//   Out        : selected word, all-zero when S is not a clean 0..3
// ---------------------------------------------------------------------------
module mux_4x2_core
  import mux_4x2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  sel_t             S,
  output logic [WIDTH-1:0] Out
);

  // Word select. A case statement (rather than a ?: tree) is used so that
  // an X or Z on S matches none of the explicit codes and falls into the
  // default branch, giving a clean zero instead of merging unselected data
  // into an X result. Out is assigned on every path so no latch is inferred.
  always_comb begin
    Out = '0;
    case (S)
      SEL_A:   Out = A;
      SEL_B:   Out = B;
      SEL_C:   Out = C;
      SEL_D:   Out = D;
      default: Out = '0;
    endcase
  end

endmodule : mux_4x2_core

// File: rtl/mux_4x2.sv
// ---------------------------------------------------------------------------
// mux_4x2
// 4:1 multiplexer with a combinational output and a one-stage registered
// copy of the result.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset (clears the registered path)
//   A..D      : WIDTH-bit data inputs, selected by S = 0..3
//   S         : 2-bit select
//   en        : capture enable for the registered path
//   Out       : combinational mux result, unaffected by clk and rst_n
//   Out_q     : mux result captured on the last enabled edge
//   S_q       : select value captured together with Out_q
//   out_valid : high for the one cycle following each capture
// ---------------------------------------------------------------------------
module mux_4x2
  import mux_4x2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       S,
  input  logic             en,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Out_q,
  output logic [1:0]       S_q,
  output logic             out_valid
);

  mux_4x2_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .A   (A),
    .B   (B),
    .C   (C),
    .D   (D),
    .S   (S),
    .Out (Out)
  );

  // Captured word and select. They only move on an enabled edge, so any
  // wiggling of S or the data between edges is invisible here. Reset clears
  // them asynchronously so a held value is dropped at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out_q <= '0;
      S_q   <= SEL_A;
    end else if (en) begin
      Out_q <= Out;
      S_q   <= S;
    end
  end

  // Capture strobe: follows en by one edge, so it is high exactly for the
  // cycle in which freshly captured data is presented on Out_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= en;
    end
  end

endmodule : mux_4x2

// File: tb/tb_mux_4x2.sv
// ---------------------------------------------------------------------------
// tb_mux_4x2
// Self-checking bench for mux_4x2: directed steps followed by randomized
// traffic, compared against a behavioural model built from the word array
// {A, B, C, D} and a "last captured" record.
// ---------------------------------------------------------------------------
module tb_mux_4x2;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] A, B, C, D;
  logic [1:0]   S;
  logic         en;
  logic [W-1:0] Out;
  logic [W-1:0] Out_q;
  logic [1:0]   S_q;
  logic         out_valid;

  int checkCount;
  int errorCount;

  // model of the registered path
  logic [W-1:0] expOutQ;
  logic [1:0]   expSQ;
  logic         expValid;

  mux_4x2 #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .S         (S),
    .en        (en),
    .Out       (Out),
    .Out_q     (Out_q),
    .S_q       (S_q),
    .out_valid (out_valid)
  );

  // free-running 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference select: pick entry S of the word array, zero on unknown S
  function automatic logic [W-1:0] refMux(input logic [1:0] sel);
    logic [W-1:0] words [4];
    words[0] = A;
    words[1] = B;
    words[2] = C;
    words[3] = D;
    if ($isunknown(sel)) return '0;
    return words[int'(sel)];
  endfunction

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] c, input logic [W-1:0] d,
                               input logic [1:0] s, input logic e);
    A  = a;
    B  = b;
    C  = c;
    D  = d;
    S  = s;
    en = e;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // advance one rising edge, updating the model from the values present
  // just before the edge, then settle 1 ns past the edge
  task automatic tick();
    if (!rst_n) begin
      expOutQ  = '0;
      expSQ    = 2'b00;
      expValid = 1'b0;
    end else begin
      if (en) begin
        expOutQ = refMux(S);
        expSQ   = S;
      end
      expValid = en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_out_q"}, 32'(Out_q), 32'(expOutQ));
    checkOutput({tag, "_s_q"}, 32'(S_q), 32'(expSQ));
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(expValid));
  endtask

  initial begin
    logic [1:0] s0, s1;
    logic       e0;
    checkCount = 0;
    errorCount = 0;
    expOutQ    = '0;
    expSQ      = 2'b00;
    expValid   = 1'b0;

    // reset asserted from time zero, before any clock edge
    rst_n = 1'b0;
    applyStimulus(16'd0, 16'd0, 16'd0, 16'd0, 2'd0, 1'b0);
    #2;
    checkRegs("reset_immediate");

    // Out keeps following the inputs during reset
    applyStimulus(16'd2, 16'd3, 16'd4, 16'd10000, 2'd2, 1'b1);
    #1;
    checkOutput("reset_out_tracks", 32'(Out), 32'd4);
    tick();
    tick();
    checkRegs("reset_held");

    // release away from the clock edge, with en low
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkRegs("post_reset_idle");

    // select sweep, 10 ns per step
    for (int i = 0; i < 4; i++) begin
      S = 2'(i);
      #1;
      checkOutput($sformatf("sweep_s%0d", i), 32'(Out), 32'(refMux(S)));
      #9;
    end
    checkOutput("sweep_d_const", 32'(Out), 32'd10000);

    // capture D, then hold with en low
    S  = 2'd3;
    en = 1'b1;
    tick();
    checkRegs("capture_d");
    checkOutput("capture_d_const", 32'(Out_q), 32'd10000);
    en = 1'b0;
    tick();
    checkRegs("hold_d");

    // mid-cycle select change: Out moves at once, Out_q waits for the edge
    S  = 2'd0;
    en = 1'b1;
    tick();
    checkOutput("cap_a_const", 32'(Out_q), 32'd2);
    #3;
    S = 2'd2;
    #1;
    checkOutput("midcycle_out", 32'(Out), 32'd4);
    checkOutput("midcycle_out_q_held", 32'(Out_q), 32'd2);
    tick();
    checkRegs("midcycle_capture");
    checkOutput("midcycle_capture_const", 32'(Out_q), 32'd4);

    // full-scale data and unknown select
    en = 1'b0;
    D  = 16'hFFFF;
    S  = 2'd3;
    #1;
    checkOutput("full_scale_out", 32'(Out), 32'h0000FFFF);
    S = 2'b1x;
    #1;
    checkOutput("unknown_sel_out", 32'(Out), 32'(refMux(S)));
    S = 2'd3;
    en = 1'b1;
    tick();
    checkRegs("full_scale_capture");

    // reset between edges discards the held value immediately
    D = 16'd10000;
    tick();
    checkRegs("pre_midreset");
    #2;
    rst_n    = 1'b0;
    expOutQ  = '0;
    expSQ    = 2'b00;
    expValid = 1'b0;
    #1;
    checkRegs("midreset_immediate");
    S = 2'd1;
    #1;
    checkOutput("midreset_out_tracks", 32'(Out), 32'd3);

    // first capture happens on the first edge after release with en high
    @(negedge clk);
    rst_n = 1'b1;
    S     = 2'd2;
    en    = 1'b1;
    tick();
    checkRegs("first_capture");

    // randomized traffic, inputs changed twice between edges
    for (int i = 0; i < 60; i++) begin
      s0 = 2'($urandom_range(0, 3));
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    s0, 1'($urandom));
      #1;
      checkOutput($sformatf("rand%0d_out_a", i), 32'(Out), 32'(refMux(S)));
      s1 = 2'($urandom_range(0, 3));
      e0 = 1'($urandom_range(0, 3) != 0);
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    s1, e0);
      #1;
      checkOutput($sformatf("rand%0d_out_b", i), 32'(Out), 32'(refMux(S)));
      tick();
      checkRegs($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule : tb_mux_4x2
